// File: rtl/spi_master_mc.sv
// spi_master_mc: single-transfer SPI master with per-request mode, bit order
// and chip-select. Edges are generated from a half-period counter; the
// transfer runs IDLE -> SETUP -> XFER -> HOLD -> DONE -> IDLE.
module spi_master_mc #(
    parameter int DATAWIDTH = 16,
    parameter int CSNUM     = 4,
    parameter int CLKDIV    = 8
) (
    input  logic                                          I_clk,
    input  logic                                          I_rst,
    input  logic [DATAWIDTH-1:0]                          I_send_data,
    input  logic [((CSNUM > 1) ? $clog2(CSNUM) : 1)-1:0]  I_cs_sel,
    input  logic                                          I_cpol,
    input  logic                                          I_cpha,
    input  logic                                          I_lsb_first,
    input  logic                                          I_valid,
    output logic                                          O_busy,
    output logic                                          O_done,
    output logic                                          O_err,
    output logic [DATAWIDTH-1:0]                          O_recv_data,
    output logic [CSNUM-1:0]                              O_cs,
    output logic                                          O_sclk,
    output logic                                          O_mosi,
    input  logic                                          I_miso
);
    localparam int CSW  = (CSNUM > 1) ? $clog2(CSNUM) : 1;
    localparam int HALF = CLKDIV / 2;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int EW   = $clog2(2 * DATAWIDTH);

    localparam logic [HW-1:0] HLAST  = HW'(HALF - 1);
    localparam logic [EW-1:0] ELAST  = EW'(2 * DATAWIDTH - 1);
    localparam logic [CSW:0]  CS_LIM = CSNUM[CSW:0];

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]           state;
    logic [HW-1:0]        hcnt;
    logic [EW-1:0]        ecnt;      // index of the last SCLK edge issued
    logic [DATAWIDTH-1:0] tx_sr;
    logic [DATAWIDTH-1:0] rx_sr;
    logic [DATAWIDTH-1:0] recv_q;
    logic [CSW-1:0]       sel_q;
    logic                 cpol_q, cpha_q, lsb_q;
    logic                 mosi_en;   // MOSI carries data (CPHA=1 waits for first leading edge)
    logic                 sclk_q;
    logic                 err_q;

    logic                 half_end;
    logic                 edge_now;
    logic [EW-1:0]        edge_idx;
    logic                 lead;
    logic                 tx_bit;
    logic                 cs_act;

    assign half_end = (hcnt == HLAST);
    assign lead     = ~edge_idx[0];
    assign tx_bit   = lsb_q ? tx_sr[0] : tx_sr[DATAWIDTH-1];
    assign cs_act   = (state == S_SETUP) || (state == S_XFER) || (state == S_HOLD);

    // Edge scheduler: edge 0 closes SETUP, edges 1..2*DATAWIDTH-1 fall inside XFER.
    always_comb begin
        edge_now = 1'b0;
        edge_idx = '0;
        if (state == S_SETUP && half_end) begin
            edge_now = 1'b1;
        end else if (state == S_XFER && half_end && ecnt != ELAST) begin
            edge_now = 1'b1;
            edge_idx = ecnt + EW'(1);
        end
    end

    // Control FSM, SCLK generation, TX shifting and RX sampling.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state   <= S_IDLE;
            hcnt    <= '0;
            ecnt    <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            recv_q  <= '0;
            sel_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            mosi_en <= 1'b0;
            sclk_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (I_valid) begin
                        if ({1'b0, I_cs_sel} < CS_LIM) begin
                            tx_sr   <= I_send_data;
                            sel_q   <= I_cs_sel;
                            cpol_q  <= I_cpol;
                            cpha_q  <= I_cpha;
                            lsb_q   <= I_lsb_first;
                            sclk_q  <= I_cpol;
                            mosi_en <= ~I_cpha;
                            hcnt    <= '0;
                            state   <= S_SETUP;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    hcnt <= half_end ? '0 : hcnt + HW'(1);
                    if (half_end) begin
                        ecnt  <= '0;
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    hcnt <= half_end ? '0 : hcnt + HW'(1);
                    if (half_end) begin
                        if (ecnt == ELAST) state <= S_HOLD;
                        else               ecnt  <= ecnt + EW'(1);
                    end
                end
                S_HOLD: begin
                    hcnt <= half_end ? '0 : hcnt + HW'(1);
                    if (half_end) begin
                        recv_q <= rx_sr;
                        state  <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (edge_now) begin
                sclk_q <= ~sclk_q;
                // sample on leading edges for CPHA=0, trailing edges for CPHA=1
                if (lead ^ cpha_q)
                    rx_sr <= lsb_q ? {I_miso, rx_sr[DATAWIDTH-1:1]}
                                   : {rx_sr[DATAWIDTH-2:0], I_miso};
                if (cpha_q && lead && edge_idx == '0)
                    mosi_en <= 1'b1;
                else if ((cpha_q && lead) || (!cpha_q && !lead && edge_idx != ELAST))
                    tx_sr <= lsb_q ? {1'b0, tx_sr[DATAWIDTH-1:1]}
                                   : {tx_sr[DATAWIDTH-2:0], 1'b0};
            end
        end
    end

    // Active-low chip-select decode for the latched slave.
    always_comb begin
        O_cs = '1;
        for (int i = 0; i < CSNUM; i++)
            O_cs[i] = ~(cs_act && (sel_q == CSW'(i)));
    end

    assign O_busy      = (state != S_IDLE);
    assign O_done      = (state == S_DONE);
    assign O_err       = err_q;
    assign O_recv_data = recv_q;
    assign O_sclk      = sclk_q;
    assign O_mosi      = (state != S_IDLE) && mosi_en && tx_bit;

endmodule

// File: tb/tb_spi_master_mc.sv
// tb_spi_master_mc: directed transfers against a cycle-level behavioural
// model of the SPI master (timeline by offset from acceptance), plus a
// second small instance for out-of-range chip-select rejection.
module tb_spi_master_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] send = '0;
    logic [1:0]  sel = '0;
    logic        cpol = 1'b0, cpha = 1'b0, lsb = 1'b0, valid = 1'b0;
    logic        busy, done, err, sclk, mosi, miso;
    logic [15:0] recv;
    logic [3:0]  cs;
    int          mm = 0;   // MISO source: 0 loop, 1 inverted loop, 2 const 1, 3 const 0

    logic [2:0]  sel2 = '0;
    logic        valid2 = 1'b0;
    logic        busy2, done2, err2, sclk2, mosi2;
    logic        miso2 = 1'b0;
    logic [15:0] recv2;
    logic [4:0]  cs2;

    always #5 clk = ~clk;

    assign miso = (mm == 0) ? mosi : (mm == 1) ? ~mosi : (mm == 2);

    spi_master_mc #(.DATAWIDTH(16), .CSNUM(4), .CLKDIV(8)) dut (
        .I_clk(clk), .I_rst(rst), .I_send_data(send), .I_cs_sel(sel),
        .I_cpol(cpol), .I_cpha(cpha), .I_lsb_first(lsb), .I_valid(valid),
        .O_busy(busy), .O_done(done), .O_err(err), .O_recv_data(recv),
        .O_cs(cs), .O_sclk(sclk), .O_mosi(mosi), .I_miso(miso));

    spi_master_mc #(.DATAWIDTH(16), .CSNUM(5), .CLKDIV(8)) dut2 (
        .I_clk(clk), .I_rst(rst), .I_send_data(send), .I_cs_sel(sel2),
        .I_cpol(cpol), .I_cpha(cpha), .I_lsb_first(lsb), .I_valid(valid2),
        .O_busy(busy2), .O_done(done2), .O_err(err2), .O_recv_data(recv2),
        .O_cs(cs2), .O_sclk(sclk2), .O_mosi(mosi2), .I_miso(miso2));

    // Model: m_t counts cycles since acceptance (0..3 setup, 4..131 xfer,
    // 132..135 hold, 136 done).
    logic        m_act = 1'b0, m_err = 1'b0;
    int          m_t = 0;
    logic [15:0] m_data = '0, m_rx = '0, m_recv = '0;
    logic [1:0]  m_sel = '0;
    logic        m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0;

    // Model state advance, sampling the request inputs like the DUT does.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 1'b0; m_t <= 0; m_cpol <= 1'b0; m_cpha <= 1'b0; m_lsb <= 1'b0;
            m_recv <= '0; m_err <= 1'b0;
        end else begin
            m_err <= 1'b0;
            if (m_act) begin
                if (m_t == 136) m_act <= 1'b0;
                else begin
                    m_t <= m_t + 1;
                    if (m_t == 135) m_recv <= m_rx;
                end
            end else if (valid) begin
                if (32'(sel) < 4) begin
                    m_act <= 1'b1; m_t <= 0; m_data <= send; m_sel <= sel;
                    m_cpol <= cpol; m_cpha <= cpha; m_lsb <= lsb;
                    m_rx <= (mm == 0) ? send : (mm == 1) ? ~send : (mm == 2) ? 16'hFFFF : 16'h0000;
                end else m_err <= 1'b1;
            end
        end
    end

    function automatic logic exp_bit(input int k);
        return m_lsb ? m_data[k] : m_data[15-k];
    endfunction

    int   n_assert = 0, n_fail = 0, cyc = 0;
    int   edge_cnt = 0, cs_low = 0, last_done = -1;
    logic prev_sclk = 1'b0, prev_act = 1'b0, prev_req2 = 1'b0;
    logic [15:0] lit_recv = '0;
    logic lit_en = 1'b0, gap_en = 1'b0;
    int   gap_start = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Compare process: DUT outputs vs model every cycle, plus literal checks.
    always @(negedge clk) begin
        logic [3:0] e_cs;
        logic       e_sclk;
        int         r, k;
        cyc++;
        e_cs   = (m_act && m_t < 136) ? ~(4'b0001 << m_sel) : 4'hF;
        e_sclk = m_cpol;
        chk("busy", busy, m_act);
        chk("done", done, m_act && m_t == 136);
        chk("err", err, m_err);
        chk("cs", cs, e_cs);
        chk("recv", recv, m_recv);
        if (!m_act) chk("mosi_idle", mosi, 0);
        else if (m_t < 4 && !m_cpha) chk("mosi_setup", mosi, exp_bit(0));
        if (m_act && m_t >= 4 && m_t < 132) begin
            r = m_t - 4;
            e_sclk = m_cpol ^ ((r / 4) % 2 == 0);
            k = m_cpha ? r / 8 : (((r + 4) / 8) > 15 ? 15 : (r + 4) / 8);
            chk("mosi_xfer", mosi, exp_bit(k));
        end
        chk("sclk", sclk, e_sclk);
        if (rst) begin
            chk("rst_cs", cs, 4'hF);
            chk("rst_sclk_mosi_done", {sclk, mosi, done, busy}, 4'b0000);
        end
        // counters for per-transfer literal checks
        if (!m_act) begin
            edge_cnt = 0; cs_low = 0;
        end else begin
            if (prev_act && sclk && !prev_sclk) edge_cnt++;
            if (cs != 4'hF) cs_low++;
        end
        if (m_act && m_t == 136 && done) begin
            chk("sclk_rising_edges", edge_cnt, 16);
            chk("cs_low_cycles", cs_low, 136);
            if (lit_en) chk("recv_literal", recv, lit_recv);
            if (gap_en && last_done >= gap_start) chk("done_gap", cyc - last_done, 138);
            last_done = cyc;
        end
        prev_act  = m_act;
        prev_sclk = sclk;
        // second instance: rejected requests only
        chk("err2", err2, prev_req2);
        chk("busy2", busy2, 0);
        chk("cs2", cs2, 5'b11111);
        prev_req2 = !rst && valid2 && (sel2 >= 3'd5);
    end

    task automatic req(input logic [15:0] d, input logic [1:0] s, input logic p, input logic h,
                       input logic l, input int m, input logic [15:0] lit);
        @(posedge clk); #1;
        send = d; sel = s; cpol = p; cpha = h; lsb = l; mm = m;
        lit_recv = lit; lit_en = 1'b1; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                $display("FAIL wait_done @cycle %0d: O_done not seen within %0d cycles, required 1", cyc, budget);
                $fatal(1, "timeout");
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // mode 0, MSB first, loopback
        req(16'hAA55, 2'd0, 0, 0, 0, 0, 16'hAA55);
        wait_done(300);
        // mode 3, LSB first, MISO held high
        req(16'h0001, 2'd2, 1, 1, 1, 2, 16'hFFFF);
        wait_done(300);
        // mode 1, MSB first, inverted loopback
        req(16'h1234, 2'd1, 0, 1, 0, 1, 16'hEDCB);
        wait_done(300);
        // mode 2, LSB first, loopback
        req(16'hC3A5, 2'd3, 1, 0, 1, 0, 16'hC3A5);
        wait_done(300);

        // request while busy is ignored
        req(16'h5A5A, 2'd0, 0, 0, 0, 0, 16'h5A5A);
        repeat (20) @(posedge clk);
        #1 send = 16'hFFFF; sel = 2'd1; cpol = 1'b1; valid = 1'b1;
        @(posedge clk); #1 valid = 1'b0;
        wait_done(300);

        // out-of-range chip select on the CSNUM=5 instance
        @(posedge clk); #1 sel2 = 3'd5; valid2 = 1'b1;
        @(posedge clk); #1 valid2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 sel2 = 3'd7; valid2 = 1'b1;
        @(posedge clk); #1 valid2 = 1'b0;
        repeat (3) @(posedge clk);

        // reset at XFER cycle 50, then a clean mode-0 transfer
        req(16'h1357, 2'd1, 0, 0, 0, 0, 16'h1357);
        repeat (54) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        req(16'h0F0F, 2'd1, 0, 0, 0, 0, 16'h0F0F);
        wait_done(300);

        // back-to-back with I_valid held high
        @(posedge clk); #1;
        gap_start = cyc; gap_en = 1'b1;
        send = 16'h3C3C; sel = 2'd2; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; mm = 0;
        lit_recv = 16'h3C3C; valid = 1'b1;
        wait_done(300);
        repeat (5) @(posedge clk);
        #1 valid = 1'b0;
        wait_done(300);
        repeat (4) @(posedge clk);
        @(negedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
